data_memory: RTL and testbench

Line-wide main-memory responder on the external side of the L1 cache's miss/write-back interface. It accepts one 256-bit line read or write per request. It waits a programmable number of cycles to model DRAM latency, then completes the access and pulses an acknowledge. It is the target of `ext_mem_cs`/`ext_mem_we`/`ext_mem_addr`/`ext_mem_data_*` at CPU top level and replaces the untimed external memory stub.

---
 rtl/data_memory.sv | 116 +++++++++++
 tb/tb_data_memory.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Line-wide main-memory responder: captures one 256-bit line read or write,
// waits a programmable latency, performs the access and pulses ack_o for one cycle.
module data_memory #(
  parameter int line_count = 512,
  parameter int latency    = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cs_i,
  input  logic         we_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic [255:0] data_o,
  output logic         ack_o
);

  localparam int IDX_W = $clog2(line_count);
  localparam int CNT_W = (latency > 1) ? $clog2(latency) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(latency - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               we_q, we_d;
  logic [255:0]       wdata_q, wdata_d;
  logic               rd_valid_q, rd_valid_d;
  logic               mem_we, mem_re;
  logic [255:0]       mem_rdata_q;
  logic [255:0]       mem [0:line_count-1];

  // Offset bits and bits above the line index are deliberately ignored (aliasing).
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_i[4:0];
  generate
    if (IDX_W + 5 < 32) begin : g_unused_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_i[31:IDX_W+5];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rd_valid_d = rd_valid_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_i) begin
          state_d = BUSY;
          idx_d   = addr_i[5 +: IDX_W];
          we_d    = we_i;
          wdata_d = data_i;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ACK;
          if (we_q) begin
            mem_we = 1'b1;
          end else begin
            mem_re     = 1'b1;
            rd_valid_d = 1'b1;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Array and its read register carry no reset so they map onto block RAM;
  // rd_valid_q masks the stale read register to zero after reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
    if (mem_re) begin
      mem_rdata_q <= mem[idx_q];
    end
  end

  assign data_o = rd_valid_q ? mem_rdata_q : '0;
  assign ack_o  = (state_q == ACK);

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus random traffic
// checked against a line-array reference model.
module tb_data_memory;

  localparam int N  = 512;
  localparam int L  = 10;
  localparam int L3 = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         cs, we;
  logic [31:0]  addr;
  logic [255:0] din, dout;
  logic         ack;
  logic         cs3, we3;
  logic [31:0]  addr3;
  logic [255:0] din3, dout3;
  logic         ack3;

  int total = 0;
  int bad   = 0;

  logic [255:0] ref_mem   [0:N-1];
  bit           ref_known [0:N-1];
  logic [255:0] exp_rdata;

  data_memory #(.line_count(N), .latency(L)) u_dut (
    .clk(clk), .rst(rst), .cs_i(cs), .we_i(we), .addr_i(addr),
    .data_i(din), .data_o(dout), .ack_o(ack)
  );

  data_memory #(.line_count(N), .latency(L3)) u_dut3 (
    .clk(clk), .rst(rst), .cs_i(cs3), .we_i(we3), .addr_i(addr3),
    .data_i(din3), .data_o(dout3), .ack_o(ack3)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % N);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // One full request on the latency-10 instance; busy-time inputs are junk
  // (or a fixed write of 32'h80 when stab is set) and must not matter.
  task automatic do_req(input string tag, input logic w, input logic [31:0] a,
                        input logic [255:0] d, input bit stab);
    int  n;
    bit  seen;
    cs = 1'b1; we = w; addr = a; din = d;
    tick();
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      if (stab) begin
        cs = 1'b0; we = 1'b1; addr = 32'h80; din = rand_line();
      end else begin
        cs = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
        addr = $urandom(); din = rand_line();
      end
      tick();
      n++;
      if (ack) seen = 1;
    end
    cs = 1'b0;
    check({tag, "_lat"}, 256'(n), 256'(L));
    if (w) begin
      ref_mem[line_of(a)]   = d;
      ref_known[line_of(a)] = 1;
    end else if (ref_known[line_of(a)]) begin
      exp_rdata = ref_mem[line_of(a)];
    end
    check({tag, "_data"}, dout, exp_rdata);
    tick();
    check({tag, "_ack1"}, 256'(ack), 256'(0));
    $display("txn %s we=%0d addr=%h lat=%0d data_o=%h", tag, w, a, n, dout);
  endtask

  logic [255:0] pat, ones, junk80;
  int           pool [8];
  int           acks [$];
  int           exp_acks [$];
  int           nack;

  initial begin
    rst = 1'b1; cs = 0; we = 0; addr = 0; din = 0;
    cs3 = 0; we3 = 0; addr3 = 0; din3 = 0;
    exp_rdata = '0;
    for (int i = 0; i < N; i++) ref_known[i] = 0;
    pat  = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
            32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    ones = '1;

    // Reset applied between clock edges must act immediately.
    #7 rst = 1'b0;
    #1;
    check("rst_ack", 256'(ack), 256'(0));
    check("rst_data", dout, 256'(0));
    tick(); tick();
    rst = 1'b1;
    nack = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack) nack++;
    end
    check("idle_noack", 256'(nack), 256'(0));
    $display("txn idle20 acks=%0d", nack);

    do_req("wr40", 1'b1, 32'h40, pat, 0);
    do_req("rd40", 1'b0, 32'h40, '0, 0);
    junk80 = rand_line();
    do_req("wr80", 1'b1, 32'h80, junk80, 0);
    check("hold_after_wr", dout, pat);
    do_req("rd5c", 1'b0, 32'h5C, '0, 0);
    check("offset_rd", dout, pat);
    do_req("wr4040", 1'b1, 32'h4040, ones, 0);
    do_req("rd40_alias", 1'b0, 32'h40, '0, 0);
    check("alias_rd", dout, ones);

    // Reset in the middle of a write: no ack, line untouched, data_o cleared.
    cs = 1'b1; we = 1'b1; addr = 32'h40; din = '0;
    tick();
    cs = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b0;
    #1;
    check("abort_ack", 256'(ack), 256'(0));
    check("abort_data", dout, 256'(0));
    exp_rdata = '0;
    tick();
    rst = 1'b1;
    nack = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (ack) nack++;
    end
    check("abort_noack", 256'(nack), 256'(0));
    $display("txn abort_wr40 acks=%0d", nack);
    do_req("rd40_after_abort", 1'b0, 32'h40, '0, 0);
    check("abort_kept", dout, ones);

    // Inputs changed during BUSY must not alter the captured read.
    do_req("rd40_stab", 1'b0, 32'h40, '0, 1);
    check("stab_rd", dout, ones);
    do_req("rd80_stab", 1'b0, 32'h80, '0, 0);
    check("stab_nowr", dout, junk80);

    // Random traffic over a small pool of lines with aliased/offset addresses.
    for (int i = 0; i < 8; i++) begin
      pool[i] = $urandom_range(0, N - 1);
      do_req("rnd_init", 1'b1, 32'($urandom_range(0, 7) * N * 32 + pool[i] * 32 + $urandom_range(0, 31)),
             rand_line(), 0);
    end
    for (int i = 0; i < 30; i++) begin
      do_req("rnd", 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 7) * N * 32 + pool[$urandom_range(0, 7)] * 32 + $urandom_range(0, 31)),
             rand_line(), 0);
    end

    // Back-to-back on the latency-3 instance: ack every latency+2 cycles,
    // and a request whose cs drops during BUSY still completes exactly once.
    cs3 = 1'b1; we3 = 1'b0; addr3 = 32'h40;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (ack3) acks.push_back(i);
      if (i == 27) cs3 = 1'b0;
    end
    for (int k = 0; k < 6; k++) exp_acks.push_back(1 + L3 + k * (L3 + 2));
    check("b2b_count", 256'(acks.size()), 256'(exp_acks.size()));
    for (int k = 0; k < 6; k++) begin
      check("b2b_cycle", 256'((k < acks.size()) ? acks[k] : -1), 256'(exp_acks[k]));
    end
    $display("txn b2b acks=%0d first=%0d last=%0d", acks.size(),
             (acks.size() > 0) ? acks[0] : -1, (acks.size() > 0) ? acks[acks.size()-1] : -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
